// File: rtl/main_ram_controller_if.sv
// rtl/main_ram_controller_if.sv - cache-to-main-memory request/acknowledge bus
interface main_ram_controller_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  fetch;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic                  fetch_ack;
    logic                  flush_ack;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  busy;

    modport master (
        output fetch, flush, cache_addr, cache_wdata,
        input  fetch_ack, flush_ack, fetch_data, busy
    );

    modport slave (
        input  fetch, flush, cache_addr, cache_wdata,
        output fetch_ack, flush_ack, fetch_data, busy
    );
endinterface

// File: rtl/main_ram_controller.sv
// rtl/main_ram_controller.sv - slow word-addressed backing RAM serving cache flush/fetch
module main_ram_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 10
) (
    input  logic                  clka,
    input  logic                  rsta,
    main_ram_controller_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t                state, state_next;
    logic [7:0]            cnt;
    logic                  op_wr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  fetch_ack_q, flush_ack_q;
    logic [DATA_WIDTH-1:0] fetch_data_q;
    logic                  accept_wr, accept_rd, access;

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    always_comb begin
        state_next = state;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        access     = 1'b0;
        case (state)
            S_IDLE: begin
                // flush wins so a dirty line is written back before its refill
                if (bus.flush) begin
                    accept_wr  = 1'b1;
                    state_next = S_WAIT;
                end else if (bus.fetch) begin
                    accept_rd  = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 8'd0) begin
                    access     = 1'b1;
                    state_next = S_ACK;
                end
            end
            S_ACK: state_next = S_RELEASE;
            S_RELEASE: begin
                if (op_wr ? !bus.flush : !bus.fetch)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            cnt          <= 8'd0;
            op_wr        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fetch_ack_q  <= 1'b0;
            flush_ack_q  <= 1'b0;
            fetch_data_q <= '0;
        end else begin
            fetch_ack_q <= 1'b0;
            flush_ack_q <= 1'b0;
            if (accept_wr || accept_rd) begin
                cnt    <= LAT_M1;
                op_wr  <= accept_wr;
                addr_q <= bus.cache_addr;
                if (accept_wr) wdata_q <= bus.cache_wdata;
            end else if (state == S_WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (access) begin
                if (op_wr) begin
                    flush_ack_q <= 1'b1;
                end else begin
                    fetch_ack_q  <= 1'b1;
                    fetch_data_q <= ram[addr_q];
                end
            end
        end
    end

    // Array has no reset; an async reset forces IDLE so a pending write never lands.
    always_ff @(posedge clka) begin
        if (access && op_wr && rsta)
            ram[addr_q] <= wdata_q;
    end

    assign bus.fetch_ack  = fetch_ack_q;
    assign bus.flush_ack  = flush_ack_q;
    assign bus.fetch_data = fetch_data_q;
    assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_main_ram_controller.sv
// tb/tb_main_ram_controller.sv - randomized self-checking bench for main_ram_controller
module tb_main_ram_controller;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int L0 = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [DW-1:0] model [int];

    always #5 clk = ~clk;

    main_ram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i0 ();
    main_ram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i1 ();

    main_ram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(L0)) dut0 (
        .clka(clk), .rsta(rst_n), .bus(i0.slave));
    main_ram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1)) dut1 (
        .clka(clk), .rsta(rst_n), .bus(i1.slave));

    task automatic wait_idle0(input string tag);
        int k = 0;
        while (i0.busy && k < 20) begin
            @(posedge clk); #1; k++;
        end
        total++;
        if (i0.busy !== 1'b0) begin
            bad++; $display("FAIL %s_idle: busy=%b want 0", tag, i0.busy);
        end
    endtask

    // One complete transaction on the LATENCY=10 instance, checked against the model.
    task automatic op0(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        int k;
        logic [DW-1:0] got;
        @(negedge clk);
        i0.cache_addr = a; i0.cache_wdata = d;
        if (wr) i0.flush = 1'b1; else i0.fetch = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (!(wr ? i0.flush_ack : i0.fetch_ack) && k < 300) begin
            total++;
            if (i0.busy !== 1'b1) begin
                bad++; $display("FAIL %s_busy: busy=%b want 1 at cycle %0d", tag, i0.busy, k);
            end
            @(posedge clk); #1; k++;
        end
        total++;
        if (k != L0) begin
            bad++; $display("FAIL %s_latency: got %0d want %0d", tag, k, L0);
        end
        total++;
        if ((wr ? i0.fetch_ack : i0.flush_ack) !== 1'b0) begin
            bad++; $display("FAIL %s_wrong_ack: other ack high", tag);
        end
        got = i0.fetch_data;
        if (!wr && model.exists(int'(a))) begin
            total++;
            if (got !== model[int'(a)]) begin
                bad++; $display("FAIL %s_data: addr %0d got %0d want %0d", tag, a, got, model[int'(a)]);
            end
        end
        @(posedge clk); #1;
        total++;
        if ((wr ? i0.flush_ack : i0.fetch_ack) !== 1'b0) begin
            bad++; $display("FAIL %s_ack_width: ack still high", tag);
        end
        if (!wr) begin
            total++;
            if (i0.fetch_data !== got) begin
                bad++; $display("FAIL %s_data_hold: got %0d want %0d", tag, i0.fetch_data, got);
            end
        end
        i0.flush = 1'b0; i0.fetch = 1'b0;
        wait_idle0(tag);
        if (wr) model[int'(a)] = d;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({i0.fetch_ack, i0.flush_ack, i0.busy} !== 3'b000 || i0.fetch_data !== '0) begin
            bad++; $display("FAIL reset_outputs: acks/busy=%b%b%b data=%0d want 0", i0.fetch_ack, i0.flush_ack, i0.busy, i0.fetch_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (i0.busy !== 1'b0 || i1.busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle: busy0=%b busy1=%b want 0", i0.busy, i1.busy);
        end
    endtask

    task automatic test_basic();
        op0(1'b1, 12'd0, 32'd2123000123, "flush0");
        op0(1'b0, 12'd0, 32'd0, "fetch0");
        op0(1'b1, 12'd1000, 32'd1002003009, "flush1000");
        op0(1'b0, 12'd1000, 32'd0, "fetch1000");
        op0(1'b1, 12'd1024, 32'd998, "flush1024");
        op0(1'b0, 12'd1024, 32'd0, "fetch1024");
        op0(1'b0, 12'd0, 32'd0, "fetch0_alias");
    endtask

    task automatic test_both_high();
        int k = 0;
        int kf = 0;
        @(negedge clk);
        i0.cache_addr = 12'd5; i0.cache_wdata = 32'd77;
        i0.flush = 1'b1; i0.fetch = 1'b1;
        while (!i0.flush_ack && !i0.fetch_ack && k < 300) begin
            @(posedge clk); #1; k++;
        end
        total++;
        if (i0.flush_ack !== 1'b1 || i0.fetch_ack !== 1'b0) begin
            bad++; $display("FAIL both_order: flush_ack=%b fetch_ack=%b want 1/0", i0.flush_ack, i0.fetch_ack);
        end
        @(posedge clk); #1;
        i0.flush = 1'b0;
        model[5] = 32'd77;
        while (!i0.fetch_ack && kf < 300) begin
            @(posedge clk); #1; kf++;
        end
        // release edge, idle edge, accept edge, then the latency
        total++;
        if (kf != L0 + 2) begin
            bad++; $display("FAIL both_fetch_latency: got %0d want %0d", kf, L0 + 2);
        end
        total++;
        if (i0.fetch_data !== 32'd77) begin
            bad++; $display("FAIL both_fetch_data: got %0d want 77", i0.fetch_data);
        end
        @(negedge clk); i0.fetch = 1'b0;
        wait_idle0("both");
    endtask

    task automatic test_addr_change();
        op0(1'b1, 12'd7, $urandom, "pre7");
        fork
            op0(1'b1, 12'd11, 32'd444, "midchange");
            begin
                repeat (4) @(posedge clk);
                #2; i0.cache_addr = 12'd7; i0.cache_wdata = 32'd1;
            end
        join
        op0(1'b0, 12'd11, 32'd0, "fetch11");
        op0(1'b0, 12'd7, 32'd0, "fetch7");
    endtask

    task automatic test_drop_early();
        int k = 0;
        @(negedge clk);
        i0.cache_addr = 12'd20; i0.cache_wdata = 32'd31337; i0.flush = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); i0.flush = 1'b0;
        while (!i0.flush_ack && k < 300) begin
            @(posedge clk); #1; k++;
        end
        total++;
        if (k != L0) begin
            bad++; $display("FAIL drop_latency: got %0d want %0d", k, L0);
        end
        model[20] = 32'd31337;
        wait_idle0("drop");
        op0(1'b0, 12'd20, 32'd0, "drop_fetch");
    endtask

    task automatic test_reset_midwait();
        op0(1'b1, 12'd9, 32'd4242, "pre9");
        op0(1'b0, 12'd9, 32'd0, "pre9_fetch");
        @(negedge clk);
        i0.cache_addr = 12'd9; i0.cache_wdata = 32'd55; i0.flush = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; i0.flush = 1'b0;
        #1;
        total++;
        if ({i0.fetch_ack, i0.flush_ack, i0.busy} !== 3'b000 || i0.fetch_data !== '0) begin
            bad++; $display("FAIL rst_mid_outputs: acks/busy=%b%b%b data=%0d want 0", i0.fetch_ack, i0.flush_ack, i0.busy, i0.fetch_data);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (L0 + 2) begin
            @(posedge clk); #1;
            total++;
            if (i0.flush_ack !== 1'b0) begin
                bad++; $display("FAIL rst_mid_noack: flush_ack=1 want 0");
            end
        end
        op0(1'b0, 12'd9, 32'd0, "rst_mid_fetch");
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [8];
        for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
        for (int i = 0; i < 30; i++) begin
            logic [AW-1:0] a;
            a = pool[$urandom_range(0, 7)];
            if (!model.exists(int'(a)) || $urandom_range(0, 1) == 1)
                op0(1'b1, a, $urandom, "rand_wr");
            else
                op0(1'b0, a, 32'd0, "rand_rd");
        end
    endtask

    task automatic test_latency1();
        logic [DW-1:0] d;
        d = $urandom;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            i1.cache_addr = 12'd3; i1.cache_wdata = d;
            if (p == 0) i1.flush = 1'b1; else i1.fetch = 1'b1;
            @(posedge clk); #1;
            total++;
            if (i1.busy !== 1'b1 || i1.flush_ack !== 1'b0 || i1.fetch_ack !== 1'b0) begin
                bad++; $display("FAIL lat1_accept: busy=%b acks=%b%b want 1/00", i1.busy, i1.flush_ack, i1.fetch_ack);
            end
            @(posedge clk); #1;
            total++;
            if ((p == 0 ? i1.flush_ack : i1.fetch_ack) !== 1'b1) begin
                bad++; $display("FAIL lat1_ack: ack=0 want 1 one edge after accept (op %0d)", p);
            end
            if (p == 1) begin
                total++;
                if (i1.fetch_data !== d) begin
                    bad++; $display("FAIL lat1_data: got %0d want %0d", i1.fetch_data, d);
                end
            end
            @(posedge clk); #1;
            total++;
            if (i1.flush_ack !== 1'b0 || i1.fetch_ack !== 1'b0) begin
                bad++; $display("FAIL lat1_ack_width: ack still high");
            end
            i1.flush = 1'b0; i1.fetch = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            total++;
            if (i1.busy !== 1'b0) begin
                bad++; $display("FAIL lat1_idle: busy=1 want 0");
            end
        end
    endtask

    initial begin
        i0.fetch = 1'b0; i0.flush = 1'b0; i0.cache_addr = '0; i0.cache_wdata = '0;
        i1.fetch = 1'b0; i1.flush = 1'b0; i1.cache_addr = '0; i1.cache_wdata = '0;
        test_reset();
        test_basic();
        test_both_high();
        test_addr_change();
        test_drop_early();
        test_reset_midwait();
        test_random();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/main_ram_controller.md
Name: main_ram_controller

Overview:
- Backing-store stage directly downstream of unified_cache_1024_words.
- Services the cache's flush (write-back) and fetch (miss fill) requests against an internal word-addressed RAM array, with a parameterised access latency.
- Returns flush_ack / fetch_ack with fetched data, so the cache sees a slow main memory behind a two-phase request/acknowledge handshake.

Parameters:
ADDR_WIDTH, 12, word address width; RAM depth is 2**ADDR_WIDTH words.
DATA_WIDTH, 32, word width.
LATENCY, 10, cycles from request acceptance to ack; legal range 1..255.

Ports:
clka  input  1  clock; all state changes on rising edge.
rsta  input  1  reset, asynchronous, active-low (0 = reset).
fetch  input  1  cache read request; level, held until fetch_ack seen.
flush  input  1  cache write-back request; level, held until flush_ack seen.
cache_addr  input  ADDR_WIDTH  word address for fetch/flush.
cache_wdata  input  DATA_WIDTH  write-back data for flush.
fetch_ack  output  1  one-cycle pulse: fetch_data valid.
flush_ack  output  1  one-cycle pulse: write committed.
fetch_data  output  DATA_WIDTH  registered read data; holds until next fetch completes.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rsta=0, async): state=IDLE; fetch_ack=0, flush_ack=0, fetch_data=0, busy=0; latency counter=0; any in-flight access aborted and its write discarded. RAM array is not cleared.
- States: IDLE, WAIT, ACK, RELEASE.
- IDLE:
  - flush=1 on a rising edge: accept write; latch cache_addr, cache_wdata, op=WR.
  - else fetch=1: accept read; latch cache_addr, op=RD.
  - flush has priority when both are high.
  - On accept: counter<=LATENCY-1, go WAIT.
- WAIT:
  - counter!=0: decrement.
  - counter==0: perform access. WR: ram[addr]<=wdata. RD: fetch_data<=ram[addr]. Go ACK; the matching ack is registered high in the same edge.
- Latency: request sampled at edge N → ack high from edge N+LATENCY to N+LATENCY+1 (exactly one cycle).
- ACK: ack<=0, go RELEASE.
- RELEASE:
  - Stay until the serviced request line (flush for WR, fetch for RD) is sampled low, then IDLE.
  - The other request line is ignored here. A fetch held high during a flush is accepted in IDLE afterwards: flush-then-fill order.
- Address/data changes after acceptance are ignored (latched copy used).
- Request dropped before ack (protocol violation): access still completes and acks. The write is still committed.
- fetch_data changes only on RD completion or reset; WR never alters it.
- A fetch to an address written by a completed flush returns the flushed value (no forwarding needed: strictly sequential).
- LATENCY=1: ack one edge after acceptance; WAIT is entered once with counter 0.
- Minimum turnaround request→next accept: LATENCY+3 cycles.

Test Plan:
- Reset, then flush with addr=0, wdata=2123000123 → flush_ack pulses exactly one cycle, 10 edges after acceptance; busy high throughout.
- Then fetch addr=0, held until ack → fetch_ack one cycle at acceptance+10; fetch_data=2123000123 and stays after ack drops.
- Fetch addr=1000 after flush addr=1000 wdata=1002003009; then flush addr=1024 wdata=998 → fetch addr=1024 gives 998, and fetch addr=0 still gives 2123000123 (no aliasing).
- fetch and flush raised together (flush addr=5 data=77, same addr for fetch) → flush_ack first; fetch accepted only after flush released; fetch_data=77.
- Change cache_addr/cache_wdata mid-WAIT of a flush to addr=7 data=1 → original address written; ram[7] unchanged.
- Assert rsta=0 for one cycle mid-WAIT of flush addr=9 data=55 → no ack, outputs 0 immediately; later fetch addr=9 returns prior contents (not 55). Repeat with LATENCY=1 build: ack one edge after acceptance.
